// File: rtl/tt_um_hoene_pkg.sv
// Shared types and default timing constants for the pulse decoder.
package tt_um_hoene_pkg;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_IDLE = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } state_e;

   localparam int WORD_BITS_DEF  = 24;
   localparam int CNT_W_DEF      = 8;
   localparam int T_THRESH_DEF   = 8;
   localparam int T_MAX_HIGH_DEF = 32;
   localparam int T_RESET_DEF    = 64;

endpackage

// File: rtl/tt_um_hoene_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc loads 1.
module tt_um_hoene_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] value
);

   logic [CNT_W-1:0] value_q, value_d;

   // next count: clear has priority, increment stops at all-ones
   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = inc ? CNT_W'(1) : '0;
      end else if (inc && (value_q != '1)) begin
         value_d = value_q + 1'b1;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (!rst_n) value_q <= '0;
      else        value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/tt_um_hoene_pulse_decoder.sv
// Pulse-width bit decoder: serial line -> WORD_BITS words (MSB first) on valid/ready.
//
// state | meaning
// SYNC  | waiting for a T_RESET low gap before trusting the line
// IDLE  | synchronised, waiting for the first high of a bit
// HIGH  | measuring high time of the current bit
// LOW   | bit shifted in, measuring low time (next bit or frame gap)
module tt_um_hoene_pulse_decoder
   import tt_um_hoene_pkg::*;
#(
   parameter int WORD_BITS  = WORD_BITS_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int T_THRESH   = T_THRESH_DEF,
   parameter int T_MAX_HIGH = T_MAX_HIGH_DEF,
   parameter int T_RESET    = T_RESET_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 din,
   input  logic                 src_sel,
   output logic [WORD_BITS-1:0] word_data,
   output logic                 word_valid,
   input  logic                 word_ready,
   output logic                 frame_end,
   output logic                 err_pulse,
   output logic                 err_partial,
   output logic                 overflow
);

   localparam int BC_W = $clog2(WORD_BITS + 1);
   localparam logic [CNT_W-1:0] H_THRESH = CNT_W'(T_THRESH);
   localparam logic [CNT_W-1:0] H_MAX_M1 = CNT_W'(T_MAX_HIGH - 1);
   localparam logic [CNT_W-1:0] L_RST_M1 = CNT_W'(T_RESET - 1);
   localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(WORD_BITS - 1);

   state_e               state_q, state_d;
   logic                 src_q, src_d;
   logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [WORD_BITS-1:0] shreg_q, shreg_d;
   logic [WORD_BITS-1:0] word_data_q, word_data_d;
   logic                 word_valid_q, word_valid_d;
   logic                 frame_end_q, frame_end_d;
   logic                 err_pulse_q, err_pulse_d;
   logic                 err_partial_q, err_partial_d;
   logic                 overflow_q, overflow_d;

   logic [CNT_W-1:0]     hcnt, lcnt;
   logic                 hcnt_clr, hcnt_inc, lcnt_clr, lcnt_inc;
   logic                 new_bit, word_offer;
   logic [WORD_BITS-1:0] shifted;

   tt_um_hoene_sat_counter #(.CNT_W(CNT_W)) u_hcnt (
      .clk(clk), .rst_n(rst_n), .clr(hcnt_clr), .inc(hcnt_inc), .value(hcnt)
   );

   tt_um_hoene_sat_counter #(.CNT_W(CNT_W)) u_lcnt (
      .clk(clk), .rst_n(rst_n), .clr(lcnt_clr), .inc(lcnt_inc), .value(lcnt)
   );

   assign new_bit = (hcnt >= H_THRESH);
   assign shifted = {shreg_q[WORD_BITS-2:0], new_bit};

   // bit decoding, gap detection, resync and output-register handshake
   always_comb begin
      state_d       = state_q;
      src_d         = src_q;
      bit_cnt_d     = bit_cnt_q;
      shreg_d       = shreg_q;
      word_data_d   = word_data_q;
      word_valid_d  = word_valid_q;
      frame_end_d   = 1'b0;
      err_pulse_d   = 1'b0;
      err_partial_d = 1'b0;
      overflow_d    = 1'b0;
      hcnt_clr      = 1'b0;
      hcnt_inc      = 1'b0;
      lcnt_clr      = 1'b0;
      lcnt_inc      = 1'b0;
      word_offer    = 1'b0;

      if (src_sel != src_q) begin
         // source switched: whatever was half-received belongs to the old source
         src_d         = src_sel;
         state_d       = ST_SYNC;
         bit_cnt_d     = '0;
         shreg_d       = '0;
         hcnt_clr      = 1'b1;
         lcnt_clr      = 1'b1;
         err_partial_d = (bit_cnt_q != '0);
      end else begin
         case (state_q)
            ST_SYNC: begin
               if (din) begin
                  lcnt_clr = 1'b1;
               end else begin
                  lcnt_inc = 1'b1;
                  if (lcnt >= L_RST_M1) state_d = ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (din) begin
                  hcnt_clr = 1'b1;
                  hcnt_inc = 1'b1;
                  state_d  = ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (din) begin
                  hcnt_inc = 1'b1;
                  if (hcnt >= H_MAX_M1) begin
                     err_pulse_d = 1'b1;
                     bit_cnt_d   = '0;
                     shreg_d     = '0;
                     lcnt_clr    = 1'b1;
                     state_d     = ST_SYNC;
                  end
               end else begin
                  lcnt_clr = 1'b1;
                  lcnt_inc = 1'b1;
                  state_d  = ST_LOW;
                  if (bit_cnt_q == BC_LAST) begin
                     word_offer = 1'b1;
                     bit_cnt_d  = '0;
                     shreg_d    = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                     shreg_d   = shifted;
                  end
               end
            end
            ST_LOW: begin
               if (din) begin
                  hcnt_clr = 1'b1;
                  hcnt_inc = 1'b1;
                  state_d  = ST_HIGH;
               end else begin
                  lcnt_inc = 1'b1;
                  if (lcnt >= L_RST_M1) begin
                     frame_end_d   = 1'b1;
                     err_partial_d = (bit_cnt_q != '0);
                     bit_cnt_d     = '0;
                     shreg_d       = '0;
                     state_d       = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_SYNC;
         endcase
      end

      // a word only enters the output register if the slot is free or emptying now
      if (word_offer) begin
         if (!word_valid_q || word_ready) begin
            word_data_d  = shifted;
            word_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (word_valid_q && word_ready) begin
         word_valid_d = 1'b0;
      end
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_SYNC;
         src_q         <= src_sel;
         bit_cnt_q     <= '0;
         shreg_q       <= '0;
         word_data_q   <= '0;
         word_valid_q  <= 1'b0;
         frame_end_q   <= 1'b0;
         err_pulse_q   <= 1'b0;
         err_partial_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         src_q         <= src_d;
         bit_cnt_q     <= bit_cnt_d;
         shreg_q       <= shreg_d;
         word_data_q   <= word_data_d;
         word_valid_q  <= word_valid_d;
         frame_end_q   <= frame_end_d;
         err_pulse_q   <= err_pulse_d;
         err_partial_q <= err_partial_d;
         overflow_q    <= overflow_d;
      end
   end

   assign word_data   = word_data_q;
   assign word_valid  = word_valid_q;
   assign frame_end   = frame_end_q;
   assign err_pulse   = err_pulse_q;
   assign err_partial = err_partial_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_tt_um_hoene_pulse_decoder.sv
// Directed bench for the pulse decoder; event counters are kept by a negedge monitor.
module tb_tt_um_hoene_pulse_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        din = 1'b0;
   logic        src_sel = 1'b0;
   logic        word_ready = 1'b0;
   logic [23:0] word_data;
   logic        word_valid, frame_end, err_pulse, err_partial, overflow;

   int checks = 0;
   int passed = 0;

   int          xfer_cnt, valid_cyc, fe_cnt, ep_cnt, epa_cnt, ov_cnt, fe_epa_cnt, fe_ep_cnt;
   logic [23:0] last_data;

   tt_um_hoene_pulse_decoder dut (
      .clk(clk), .rst_n(rst_n), .din(din), .src_sel(src_sel),
      .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
      .frame_end(frame_end), .err_pulse(err_pulse), .err_partial(err_partial),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // event monitor, sampled mid-cycle; cleared while reset is held
   always @(negedge clk) begin
      if (!rst_n) begin
         xfer_cnt = 0; valid_cyc = 0; fe_cnt = 0; ep_cnt = 0; epa_cnt = 0;
         ov_cnt = 0; fe_epa_cnt = 0; fe_ep_cnt = 0; last_data = '0;
      end else begin
         if (word_valid) valid_cyc++;
         if (word_valid && word_ready) begin
            xfer_cnt++;
            last_data = word_data;
         end
         if (frame_end) fe_cnt++;
         if (err_pulse) ep_cnt++;
         if (err_partial) epa_cnt++;
         if (overflow) ov_cnt++;
         if (frame_end && err_partial) fe_epa_cnt++;
         if (frame_end && err_pulse) fe_ep_cnt++;
      end
   end

   task automatic drive(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         din = v;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      drive(1'b1, b ? 12 : 4);
      drive(1'b0, b ? 6 : 14);
   endtask

   task automatic send_word(input logic [23:0] w, input int nbits);
      for (int i = 23; i > 23 - nbits; i--) send_bit(w[i]);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      din = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      settle();
      rst_n = 1'b1;
   endtask

   task automatic handshake();
      word_ready = 1'b1;
      @(posedge clk);
      #1;
      word_ready = 1'b0;
      settle();
   endtask

   task automatic test_reset();
      word_ready = 1'b0;
      apply_reset();
      checks++; if (word_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", word_valid); else passed++;
      checks++; if (word_data !== 24'h0) $display("FAIL rst_data: got %h want 000000", word_data); else passed++;
      checks++; if ({frame_end, err_pulse, err_partial, overflow} !== 4'b0)
         $display("FAIL rst_pulses: got %b want 0000", {frame_end, err_pulse, err_partial, overflow}); else passed++;
      // reset in the middle of a word must leave nothing behind
      drive(1'b0, 70);
      send_word(24'hABCDEF, 12);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, 100);
      checks++; if (fe_cnt + epa_cnt + ep_cnt !== 0)
         $display("FAIL rst_midword_pulses: got fe=%0d epa=%0d ep=%0d want 0", fe_cnt, epa_cnt, ep_cnt); else passed++;
      checks++; if (word_valid !== 1'b0) $display("FAIL rst_midword_valid: got %b want 0", word_valid); else passed++;
   endtask

   task automatic test_basic_word();
      word_ready = 1'b1;
      apply_reset();
      drive(1'b0, 70);
      send_word(24'hA5C33C, 24);
      checks++; if (xfer_cnt !== 1) $display("FAIL t1_xfer: got %0d want 1", xfer_cnt); else passed++;
      checks++; if (last_data !== 24'hA5C33C) $display("FAIL t1_data: got %h want a5c33c", last_data); else passed++;
      checks++; if (valid_cyc !== 1) $display("FAIL t1_valid_cycles: got %0d want 1", valid_cyc); else passed++;
      drive(1'b0, 49);
      settle();
      checks++; if (fe_cnt !== 0) $display("FAIL t1_fe_early: got %0d want 0", fe_cnt); else passed++;
      drive(1'b0, 1);
      settle();
      checks++; if (fe_cnt !== 1) $display("FAIL t1_fe_at_64: got %0d want 1", fe_cnt); else passed++;
      drive(1'b0, 80);
      checks++; if (fe_cnt !== 1) $display("FAIL t1_fe_once: got %0d want 1", fe_cnt); else passed++;
      checks++; if (ep_cnt + epa_cnt + ov_cnt !== 0)
         $display("FAIL t1_errors: got ep=%0d epa=%0d ov=%0d want 0", ep_cnt, epa_cnt, ov_cnt); else passed++;
   endtask

   task automatic test_no_sync();
      word_ready = 1'b1;
      apply_reset();
      send_word(24'hFFFFFF, 24);
      drive(1'b0, 40);
      checks++; if (valid_cyc !== 0) $display("FAIL t2_valid: got %0d want 0", valid_cyc); else passed++;
      checks++; if (fe_cnt + ep_cnt + epa_cnt + ov_cnt !== 0)
         $display("FAIL t2_pulses: got fe=%0d ep=%0d epa=%0d ov=%0d want 0", fe_cnt, ep_cnt, epa_cnt, ov_cnt); else passed++;
      drive(1'b0, 30);
      send_word(24'h0F0F0F, 24);
      drive(1'b0, 10);
      checks++; if (xfer_cnt !== 1 || last_data !== 24'h0F0F0F)
         $display("FAIL t2_after_sync: got n=%0d data=%h want n=1 data=0f0f0f", xfer_cnt, last_data); else passed++;
   endtask

   task automatic test_overflow();
      word_ready = 1'b0;
      apply_reset();
      drive(1'b0, 70);
      send_word(24'hFFFFFF, 24);
      send_word(24'h000001, 24);
      drive(1'b0, 20);
      checks++; if (ov_cnt !== 1) $display("FAIL t3_overflow: got %0d want 1", ov_cnt); else passed++;
      checks++; if (word_valid !== 1'b1) $display("FAIL t3_held_valid: got %b want 1", word_valid); else passed++;
      checks++; if (word_data !== 24'hFFFFFF) $display("FAIL t3_held_data: got %h want ffffff", word_data); else passed++;
      handshake();
      checks++; if (xfer_cnt !== 1 || last_data !== 24'hFFFFFF)
         $display("FAIL t3_xfer: got n=%0d data=%h want n=1 data=ffffff", xfer_cnt, last_data); else passed++;
      checks++; if (word_valid !== 1'b0) $display("FAIL t3_valid_drop: got %b want 0", word_valid); else passed++;
   endtask

   task automatic test_long_pulse();
      word_ready = 1'b1;
      apply_reset();
      drive(1'b0, 70);
      send_word(24'hF00000, 5);
      drive(1'b1, 31);
      settle();
      checks++; if (ep_cnt !== 0) $display("FAIL t4_err_early: got %0d want 0", ep_cnt); else passed++;
      drive(1'b1, 1);
      settle();
      checks++; if (ep_cnt !== 1) $display("FAIL t4_err_at_32: got %0d want 1", ep_cnt); else passed++;
      drive(1'b1, 8);
      drive(1'b0, 64);
      send_word(24'h123456, 24);
      drive(1'b0, 10);
      checks++; if (xfer_cnt !== 1 || last_data !== 24'h123456)
         $display("FAIL t4_recover: got n=%0d data=%h want n=1 data=123456", xfer_cnt, last_data); else passed++;
      checks++; if (ep_cnt !== 1 || fe_cnt !== 0 || epa_cnt !== 0 || fe_ep_cnt !== 0)
         $display("FAIL t4_events: got ep=%0d fe=%0d epa=%0d both=%0d want 1/0/0/0", ep_cnt, fe_cnt, epa_cnt, fe_ep_cnt); else passed++;
   endtask

   task automatic test_partial_frame();
      word_ready = 1'b1;
      apply_reset();
      drive(1'b0, 70);
      send_word(24'hAAAAAA, 10);
      drive(1'b0, 49);
      settle();
      checks++; if (fe_cnt !== 0 || epa_cnt !== 0)
         $display("FAIL t5_early: got fe=%0d epa=%0d want 0/0", fe_cnt, epa_cnt); else passed++;
      drive(1'b0, 1);
      settle();
      checks++; if (fe_epa_cnt !== 1 || epa_cnt !== 1)
         $display("FAIL t5_fe_partial: got same=%0d epa=%0d want 1/1", fe_epa_cnt, epa_cnt); else passed++;
      checks++; if (valid_cyc !== 0) $display("FAIL t5_valid: got %0d want 0", valid_cyc); else passed++;
   endtask

   task automatic test_resync();
      word_ready = 1'b0;
      apply_reset();
      drive(1'b0, 70);
      send_word(24'hC0FFEE, 24);
      send_word(24'h5A5A5A, 5);
      src_sel = ~src_sel;
      drive(1'b0, 1);
      settle();
      checks++; if (epa_cnt !== 1) $display("FAIL t6_partial: got %0d want 1", epa_cnt); else passed++;
      checks++; if (word_valid !== 1'b1 || word_data !== 24'hC0FFEE)
         $display("FAIL t6_held: got v=%b data=%h want v=1 data=c0ffee", word_valid, word_data); else passed++;
      drive(1'b0, 30);
      send_word(24'h123123, 24);
      checks++; if (ov_cnt !== 0) $display("FAIL t6_sync_ignores: got ov=%0d want 0", ov_cnt); else passed++;
      handshake();
      checks++; if (xfer_cnt !== 1 || last_data !== 24'hC0FFEE)
         $display("FAIL t6_xfer_held: got n=%0d data=%h want n=1 data=c0ffee", xfer_cnt, last_data); else passed++;
      word_ready = 1'b1;
      drive(1'b0, 64);
      send_word(24'h5A5A5A, 24);
      drive(1'b0, 10);
      checks++; if (xfer_cnt !== 2 || last_data !== 24'h5A5A5A)
         $display("FAIL t6_next_word: got n=%0d data=%h want n=2 data=5a5a5a", xfer_cnt, last_data); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic_word();
      test_no_sync();
      test_overflow();
      test_long_pulse();
      test_partial_frame();
      test_resync();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
